// File: rtl/spi_lite_seq.sv
// spi_lite_seq: AXI4-Lite master that initialises a spi_lite core, then runs one byte transfer per request.
// Latency: each bus op takes 4 cycles on a zero-wait slave, so accept -> rsp_valid_o is 13 cycles with an immediate interrupt.
// Backpressure: req_ready_o only in IDLE; the response is held until rsp_ready_i; AXI valids are held until their ready.
// Ports: clk_i/rst_ni; client req_* / rsp_*; init_done_o, busy_o status; m_aw*/m_w*/m_b*/m_ar*/m_r* AXI-Lite
// master toward spi_lite cfg; spi_intr_i is the spi_lite level interrupt.
module spi_lite_seq #(
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter logic [31:0] CR_VALUE  = 32'h0000_00C6,
   parameter int          TMO_W     = 16,
   parameter int          TMO_CYC   = 4096
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        req_valid_i,
   input  logic [7:0]  req_data_i,
   output logic        req_ready_o,
   output logic        rsp_valid_o,
   input  logic        rsp_ready_i,
   output logic [7:0]  rsp_data_o,
   output logic        rsp_err_o,
   output logic        init_done_o,
   output logic        busy_o,
   output logic        m_awvalid_o,
   output logic [31:0] m_awaddr_o,
   input  logic        m_awready_i,
   output logic        m_wvalid_o,
   output logic [31:0] m_wdata_o,
   output logic [3:0]  m_wstrb_o,
   input  logic        m_wready_i,
   input  logic        m_bvalid_i,
   input  logic [1:0]  m_bresp_i,
   output logic        m_bready_o,
   output logic        m_arvalid_o,
   output logic [31:0] m_araddr_o,
   input  logic        m_arready_i,
   input  logic        m_rvalid_i,
   input  logic [31:0] m_rdata_i,
   input  logic [1:0]  m_rresp_i,
   output logic        m_rready_o,
   input  logic        spi_intr_i
);

   localparam logic [3:0] INIT_GIE = 4'd0;
   localparam logic [3:0] INIT_IER = 4'd1;
   localparam logic [3:0] INIT_CR  = 4'd2;
   localparam logic [3:0] IDLE     = 4'd3;
   localparam logic [3:0] TX_DTR   = 4'd4;
   localparam logic [3:0] WAIT_IRQ = 4'd5;
   localparam logic [3:0] CLR_ISR  = 4'd6;
   localparam logic [3:0] RD_DRR   = 4'd7;
   localparam logic [3:0] RESP     = 4'd8;

   localparam logic [31:0] OFS_DGIER = 32'h1C;
   localparam logic [31:0] OFS_IPISR = 32'h20;
   localparam logic [31:0] OFS_IPIER = 32'h28;
   localparam logic [31:0] OFS_SPICR = 32'h60;
   localparam logic [31:0] OFS_DTR   = 32'h68;
   localparam logic [31:0] OFS_DRR   = 32'h6C;

   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYC - 1);

   logic [3:0]       state, state_d;
   logic             op_act;      // bus op of the current state has been launched
   logic             op_fin;      // B or R handshake done; state advances this cycle
   logic [7:0]       tx_byte;
   logic [7:0]       rd_byte;
   logic             err;
   logic [TMO_W-1:0] tmo_cnt;

   logic             op_is_wr, op_is_rd, launch, in_xfer;
   logic [31:0]      op_addr, op_data;
   logic             aw_left, w_left, tmo_hit;
   logic             unused_rdata;

   assign unused_rdata = ^m_rdata_i[31:8];

   // Which bus op the current state performs, and with what address/data.
   always_comb begin
      op_is_wr = 1'b0;
      op_is_rd = 1'b0;
      op_addr  = '0;
      op_data  = '0;
      case (state)
         INIT_GIE: begin op_is_wr = 1'b1; op_addr = BASE_ADDR + OFS_DGIER; op_data = 32'h8000_0000; end
         INIT_IER: begin op_is_wr = 1'b1; op_addr = BASE_ADDR + OFS_IPIER; op_data = 32'h0000_0004; end
         INIT_CR:  begin op_is_wr = 1'b1; op_addr = BASE_ADDR + OFS_SPICR; op_data = CR_VALUE;      end
         TX_DTR:   begin op_is_wr = 1'b1; op_addr = BASE_ADDR + OFS_DTR;   op_data = {24'h0, tx_byte}; end
         CLR_ISR:  begin op_is_wr = 1'b1; op_addr = BASE_ADDR + OFS_IPISR; op_data = 32'h0000_0004; end
         RD_DRR:   begin op_is_rd = 1'b1; op_addr = BASE_ADDR + OFS_DRR; end
         default:  ;
      endcase
   end

   assign launch  = (op_is_wr || op_is_rd) && !op_act;
   assign in_xfer = (state == TX_DTR) || (state == CLR_ISR);
   // Channels still waiting for their ready after this edge.
   assign aw_left = m_awvalid_o && !m_awready_i;
   assign w_left  = m_wvalid_o && !m_wready_i;
   assign tmo_hit = (tmo_cnt == TMO_LAST);

   always_comb begin
      state_d = state;
      case (state)
         INIT_GIE: if (op_fin) state_d = INIT_IER;
         INIT_IER: if (op_fin) state_d = INIT_CR;
         INIT_CR:  if (op_fin) state_d = IDLE;
         IDLE:     if (req_valid_i) state_d = TX_DTR;
         TX_DTR:   if (op_fin) state_d = WAIT_IRQ;
         WAIT_IRQ: begin
            if (spi_intr_i)   state_d = CLR_ISR;
            else if (tmo_hit) state_d = RESP;
         end
         CLR_ISR:  if (op_fin) state_d = RD_DRR;
         RD_DRR:   if (op_fin) state_d = RESP;
         RESP:     if (rsp_ready_i) state_d = IDLE;
         default:  state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state       <= INIT_GIE;
         busy_o      <= 1'b0;
         op_act      <= 1'b0;
         op_fin      <= 1'b0;
         m_awvalid_o <= 1'b0;
         m_awaddr_o  <= '0;
         m_wvalid_o  <= 1'b0;
         m_wdata_o   <= '0;
         m_wstrb_o   <= '0;
         m_bready_o  <= 1'b0;
         m_arvalid_o <= 1'b0;
         m_araddr_o  <= '0;
         m_rready_o  <= 1'b0;
         tx_byte     <= '0;
         rd_byte     <= '0;
         err         <= 1'b0;
         init_done_o <= 1'b0;
         tmo_cnt     <= '0;
      end else begin
         state  <= state_d;
         busy_o <= (state_d != IDLE);

         if (launch) begin
            op_act <= 1'b1;
            if (op_is_wr) begin
               m_awvalid_o <= 1'b1;
               m_wvalid_o  <= 1'b1;
               m_awaddr_o  <= op_addr;
               m_wdata_o   <= op_data;
               m_wstrb_o   <= 4'hF;
            end else begin
               m_arvalid_o <= 1'b1;
               m_araddr_o  <= op_addr;
            end
         end

         if (m_awvalid_o && m_awready_i) m_awvalid_o <= 1'b0;
         if (m_wvalid_o && m_wready_i)   m_wvalid_o  <= 1'b0;

         // Raise bready only once both AW and W have completed.
         if (op_act && op_is_wr && !aw_left && !w_left && !m_bready_o && !op_fin)
            m_bready_o <= 1'b1;

         if (m_bready_o && m_bvalid_i) begin
            m_bready_o <= 1'b0;
            op_fin     <= 1'b1;
            if (in_xfer && (m_bresp_i != 2'b00)) err <= 1'b1;
            if (state == INIT_CR) init_done_o <= 1'b1;
         end

         if (m_arvalid_o && m_arready_i) begin
            m_arvalid_o <= 1'b0;
            m_rready_o  <= 1'b1;
         end

         if (m_rready_o && m_rvalid_i) begin
            m_rready_o <= 1'b0;
            op_fin     <= 1'b1;
            rd_byte    <= m_rdata_i[7:0];
            if (m_rresp_i != 2'b00) err <= 1'b1;
         end

         if (op_fin) begin
            op_act <= 1'b0;
            op_fin <= 1'b0;
         end

         if ((state == IDLE) && req_valid_i) begin
            tx_byte <= req_data_i;
            rd_byte <= '0;
         end

         if (state == WAIT_IRQ) begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
            if (!spi_intr_i && tmo_hit) begin
               err     <= 1'b1;
               rd_byte <= '0;
            end
         end
         if ((state_d == WAIT_IRQ) && (state != WAIT_IRQ)) tmo_cnt <= '0;

         if ((state == RESP) && rsp_ready_i) err <= 1'b0;
      end
   end

   assign req_ready_o = (state == IDLE);
   assign rsp_valid_o = (state == RESP);
   assign rsp_data_o  = rd_byte;
   assign rsp_err_o   = err;

endmodule

// File: tb/tb_spi_lite_seq.sv
// tb_spi_lite_seq: directed bench for spi_lite_seq with a behavioural AXI-Lite slave and interrupt source.
// Slave knobs set per test: AW/W ready delays, B delay, bad bresp on DTR, read data, interrupt delay.
module tb_spi_lite_seq;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic [7:0]  req_data = 8'h00;
   logic        req_ready;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [7:0]  rsp_data;
   logic        rsp_err;
   logic        init_done;
   logic        busy;
   logic        m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
   logic        m_arvalid, m_arready, m_rvalid, m_rready;
   logic [31:0] m_awaddr, m_wdata, m_araddr, m_rdata;
   logic [3:0]  m_wstrb;
   logic [1:0]  m_bresp, m_rresp;
   logic        spi_intr;

   always #5 clk = ~clk;

   spi_lite_seq dut (
      .clk_i(clk), .rst_ni(rst_n),
      .req_valid_i(req_valid), .req_data_i(req_data), .req_ready_o(req_ready),
      .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_data_o(rsp_data), .rsp_err_o(rsp_err),
      .init_done_o(init_done), .busy_o(busy),
      .m_awvalid_o(m_awvalid), .m_awaddr_o(m_awaddr), .m_awready_i(m_awready),
      .m_wvalid_o(m_wvalid), .m_wdata_o(m_wdata), .m_wstrb_o(m_wstrb), .m_wready_i(m_wready),
      .m_bvalid_i(m_bvalid), .m_bresp_i(m_bresp), .m_bready_o(m_bready),
      .m_arvalid_o(m_arvalid), .m_araddr_o(m_araddr), .m_arready_i(m_arready),
      .m_rvalid_i(m_rvalid), .m_rdata_i(m_rdata), .m_rresp_i(m_rresp), .m_rready_o(m_rready),
      .spi_intr_i(spi_intr)
   );

   int n_chk = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // ---------------- slave knobs and state ----------------
   int          aw_dly = 0, w_dly = 0, b_dly = 0, irq_dly = 0;
   logic        bad_dtr = 1'b0;
   logic [31:0] rd_val = 32'h0;

   int          aw_wc, w_wc, b_c, irq_c;
   logic        aw_seen, w_seen, irq_arm;
   logic [31:0] cur_addr;

   assign m_awready = m_awvalid && (aw_wc >= aw_dly);
   assign m_wready  = m_wvalid && (w_wc >= w_dly);
   assign m_arready = m_arvalid;

   wire        aw_hs  = m_awvalid && m_awready;
   wire        w_hs   = m_wvalid && m_wready;
   wire        ar_hs  = m_arvalid && m_arready;
   wire        aws    = aw_seen || aw_hs;
   wire        ws     = w_seen || w_hs;
   wire [31:0] wr_adr = aw_hs ? m_awaddr : cur_addr;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         aw_wc <= 0; w_wc <= 0; b_c <= 0; irq_c <= 0;
         aw_seen <= 1'b0; w_seen <= 1'b0; irq_arm <= 1'b0; cur_addr <= '0;
         m_bvalid <= 1'b0; m_bresp <= 2'b00; m_rvalid <= 1'b0; m_rdata <= '0; m_rresp <= 2'b00;
         spi_intr <= 1'b0;
      end else begin
         if (aw_hs) begin aw_wc <= 0; cur_addr <= m_awaddr; end
         else if (m_awvalid) aw_wc <= aw_wc + 1;
         if (w_hs) w_wc <= 0;
         else if (m_wvalid) w_wc <= w_wc + 1;

         if (m_bvalid && m_bready) begin
            m_bvalid <= 1'b0; aw_seen <= 1'b0; w_seen <= 1'b0; b_c <= 0;
         end else begin
            aw_seen <= aws;
            w_seen  <= ws;
            if (aws && ws && !m_bvalid) begin
               if (b_c >= b_dly) begin
                  m_bvalid <= 1'b1;
                  m_bresp  <= (bad_dtr && wr_adr == 32'h68) ? 2'b10 : 2'b00;
               end else b_c <= b_c + 1;
            end
         end

         if (ar_hs) begin m_rvalid <= 1'b1; m_rdata <= rd_val; m_rresp <= 2'b00; end
         else if (m_rvalid && m_rready) m_rvalid <= 1'b0;

         if (aw_hs && m_awaddr == 32'h68 && irq_dly >= 0) begin irq_arm <= 1'b1; irq_c <= 0; end
         else if (irq_arm) begin
            if (irq_c >= irq_dly) begin spi_intr <= 1'b1; irq_arm <= 1'b0; end
            else irq_c <= irq_c + 1;
         end
         if (aw_hs && m_awaddr == 32'h20) spi_intr <= 1'b0;
      end
   end

   // ---------------- transaction logs and protocol monitor ----------------
   logic [31:0] aw_log[$], w_log[$], ar_log[$];
   logic [3:0]  s_log[$];
   int          viol = 0, rsp_rise = 0, aw_cyc = 0, w_cyc = 0;
   logic        aw_hold, w_hold, ar_hold, rv_q;

   always @(posedge clk) begin
      if (aw_hs) aw_log.push_back(m_awaddr);
      if (w_hs) begin w_log.push_back(m_wdata); s_log.push_back(m_wstrb); end
      if (ar_hs) ar_log.push_back(m_araddr);
   end

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         aw_hold <= 1'b0; w_hold <= 1'b0; ar_hold <= 1'b0; rv_q <= 1'b0;
      end else begin
         aw_hold <= m_awvalid && !m_awready;
         w_hold  <= m_wvalid && !m_wready;
         ar_hold <= m_arvalid && !m_arready;
         viol <= viol + int'(aw_hold && !m_awvalid) + int'(w_hold && !m_wvalid)
                      + int'(ar_hold && !m_arvalid)
                      + int'(m_arvalid && (m_awvalid || m_wvalid || aw_seen || w_seen || m_bvalid));
         aw_cyc <= aw_cyc + int'(m_awvalid);
         w_cyc  <= w_cyc + int'(m_wvalid);
         rv_q   <= rsp_valid;
         if (rsp_valid && !rv_q) rsp_rise <= rsp_rise + 1;
      end
   end

   // ---------------- helpers ----------------
   function automatic logic any_out();
      return |{req_ready, rsp_valid, rsp_data, rsp_err, init_done, busy, m_awvalid, m_awaddr,
               m_wvalid, m_wdata, m_wstrb, m_bready, m_arvalid, m_araddr, m_rready};
   endfunction

   task automatic wait_init();
      int t = 0;
      while (!init_done && t < 200) begin @(negedge clk); t++; end
      check("init_done", 32'(init_done), 32'd1);
      @(negedge clk);
   endtask

   task automatic xfer(input logic [7:0] d, output logic [7:0] rd, output logic er, output int lat);
      int t = 0;
      rd = 8'h00; er = 1'b0; lat = -1;
      @(negedge clk);
      req_valid = 1'b1; req_data = d;
      while (!req_ready && t < 50) begin @(negedge clk); t++; end
      if (!req_ready) begin
         check("req_accept", 32'(req_ready), 32'd1);
         req_valid = 1'b0;
         return;
      end
      @(negedge clk);
      req_valid = 1'b0;
      lat = 0;
      while (!rsp_valid && lat < 6000) begin @(negedge clk); lat++; end
      check("rsp_seen", 32'(rsp_valid), 32'd1);
      if (!rsp_valid) return;
      rd = rsp_data; er = rsp_err;
      repeat (2) @(negedge clk);
      check("rsp_hold", 32'(rsp_valid), 32'd1);
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      check("idle_after_rsp", 32'({req_ready, rsp_valid}), 32'd2);
   endtask

   // ---------------- directed tests ----------------
   initial begin
      logic [7:0] rd;
      logic       er;
      int         lat, b, ab, rr, c0, c1;

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_outs", 32'(any_out()), 32'd0);
      rst_n = 1'b1;

      // 1: init sequence
      wait_init();
      check("init_n_aw", 32'(aw_log.size()), 32'd3);
      check("init_a0", aw_log[0], 32'h1C);
      check("init_a1", aw_log[1], 32'h28);
      check("init_a2", aw_log[2], 32'h60);
      check("init_d0", w_log[0], 32'h8000_0000);
      check("init_d1", w_log[1], 32'h0000_0004);
      check("init_d2", w_log[2], 32'h0000_00C6);
      check("init_strb", 32'({s_log[0], s_log[1], s_log[2]}), 32'hFFF);
      check("init_no_ar", 32'(ar_log.size()), 32'd0);
      check("idle_ready", 32'({req_ready, busy}), 32'd2);

      // 2: byte AA, interrupt 20 cycles after DTR, DRR returns 5A
      irq_dly = 20; rd_val = 32'h0000_005A;
      b = aw_log.size(); ab = ar_log.size();
      xfer(8'hAA, rd, er, lat);
      check("t2_dtr_addr", aw_log[b], 32'h68);
      check("t2_dtr_data", w_log[b], 32'h0000_00AA);
      check("t2_isr_addr", aw_log[b+1], 32'h20);
      check("t2_isr_data", w_log[b+1], 32'h0000_0004);
      check("t2_drr_addr", ar_log[ab], 32'h6C);
      check("t2_rsp_data", 32'(rd), 32'h5A);
      check("t2_rsp_err", 32'(er), 32'd0);

      // Latency with zero-wait slave and immediate interrupt; upper DRR bits ignored
      irq_dly = 0; rd_val = 32'hDEAD_BEC3;
      xfer(8'h01, rd, er, lat);
      check("lat_cycles", 32'(lat), 32'd13);
      check("lat_data", 32'(rd), 32'hC3);

      // 3: awready delayed 3 cycles, wready immediate, bvalid 2 cycles later
      aw_dly = 3; w_dly = 0; b_dly = 2; rd_val = 32'h81;
      b = aw_log.size(); c0 = aw_cyc; c1 = w_cyc;
      xfer(8'h3C, rd, er, lat);
      check("t3_n_aw", 32'(aw_log.size() - b), 32'd2);
      check("t3_n_w", 32'(w_log.size() - b), 32'd2);
      check("t3_aw_cycles", 32'(aw_cyc - c0), 32'd8);
      check("t3_w_cycles", 32'(w_cyc - c1), 32'd2);
      check("t3_dtr_data", w_log[b], 32'h3C);
      check("t3_rsp", 32'({er, rd}), 32'h081);
      aw_dly = 0; b_dly = 0;

      // 4: interrupt never arrives
      irq_dly = -1; rd_val = 32'h99;
      b = aw_log.size(); ab = ar_log.size();
      xfer(8'h55, rd, er, lat);
      check("t4_lat", 32'(lat), 32'd4100);
      check("t4_err", 32'(er), 32'd1);
      check("t4_data", 32'(rd), 32'h00);
      check("t4_no_drr", 32'(ar_log.size() - ab), 32'd0);
      check("t4_no_isr", 32'(aw_log.size() - b), 32'd1);

      // 5: bad bresp on DTR, then a clean transfer
      irq_dly = 0; bad_dtr = 1'b1; rd_val = 32'h42;
      xfer(8'h10, rd, er, lat);
      check("t5_err", 32'(er), 32'd1);
      check("t5_data", 32'(rd), 32'h42);
      bad_dtr = 1'b0; rd_val = 32'h24;
      xfer(8'h11, rd, er, lat);
      check("t5_next_err", 32'(er), 32'd0);
      check("t5_next_data", 32'(rd), 32'h24);

      // 6: reset pulse during WAIT_IRQ
      irq_dly = -1;
      b = aw_log.size(); rr = rsp_rise;
      @(negedge clk);
      req_valid = 1'b1; req_data = 8'h77;
      @(negedge clk);
      req_valid = 1'b0;
      repeat (8) @(negedge clk);
      check("t6_busy", 32'({busy, rsp_valid}), 32'd2);
      #2 rst_n = 1'b0;
      #1 check("t6_async_outs", 32'(any_out()), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      wait_init();
      check("t6_n_aw", 32'(aw_log.size() - b), 32'd4);
      check("t6_a0", aw_log[b+1], 32'h1C);
      check("t6_a1", aw_log[b+2], 32'h28);
      check("t6_a2", aw_log[b+3], 32'h60);
      check("t6_no_rsp", 32'(rsp_rise - rr), 32'd0);

      // Operational again after re-init
      irq_dly = 0; rd_val = 32'h6E;
      xfer(8'hE7, rd, er, lat);
      check("t6_post_lat", 32'(lat), 32'd13);
      check("t6_post_rsp", 32'({er, rd}), 32'h06E);

      check("axi_protocol", 32'(viol), 32'd0);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
